// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit and its helpers.
// Contents: opcode constants, FSM state encoding, instruction classes,
// 4-bit ALU operation encodings, trap cause codes and an opcode classifier.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILLEGAL
  } instr_class_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic instr_class_t classify(input logic [6:0] opcode);
    case (opcode)
      OP_R:      return CLS_R;
      OP_I:      return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      default:   return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle.
// master: the control FSM (takes instruction fields and mem_ready, drives strobes).
// slave:  the datapath/memory side (drives instruction fields and mem_ready).
// Fields: opcode/funct3/funct7_b5 from the IR, mem_ready handshake, datapath
// strobes (pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, alu_op,
// branch) and debug/status (state_o, trap, trap_cause).
interface multicycle_control_unit_if #(
  parameter int ALU_OP_W = 4
);
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                funct7_b5;
  logic                mem_ready;
  logic                pc_write;
  logic                ir_write;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                alu_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                branch;
  logic [2:0]          state_o;
  logic                trap;
  logic [1:0]          trap_cause;

  modport master (
    input  opcode, funct3, funct7_b5, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, alu_src,
           alu_op, branch, state_o, trap, trap_cause
  );

  modport slave (
    output opcode, funct3, funct7_b5, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, alu_src,
           alu_op, branch, state_o, trap, trap_cause
  );
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational ALU operation decode from instruction class and funct fields.
// Ports: cls (latched instruction class), funct3, funct7_b5 -> alu_op
// (4-bit encoding zero-extended to ALU_OP_W).
module alu_op_decoder
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  instr_class_t        cls,
  input  logic [2:0]          funct3,
  input  logic                funct7_b5,
  output logic [ALU_OP_W-1:0] alu_op
);

  logic [3:0] op;

  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    op = ALU_ADD;
    case (cls)
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000:  op = (cls == CLS_R && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;  // SRAI/SRA share bit 30
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      CLS_BRANCH: op = ALU_SUB;
      default:    op = ALU_ADD;  // LOAD/STORE address add
    endcase
  end

  assign alu_op = ALU_OP_W'(op);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Ports: clk, rst_n (async active-low), bus (master modport: instruction
// fields and mem_ready in; datapath strobes, state_o, trap, trap_cause out).
// Memory waits in FETCH/MEM are bounded by MAX_WAIT; overrun traps with cause
// TIMEOUT, an unknown opcode traps with cause ILLEGAL. Only reset leaves TRAP.
module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter  int ALU_OP_W = 4,
  parameter  int MAX_WAIT = 16,
  localparam int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input logic                        clk,
  input logic                        rst_n,
  multicycle_control_unit_if.master  bus
);

  state_t              state, next_state;
  instr_class_t        cls;
  logic [CNT_W-1:0]    wait_cnt;
  logic [1:0]          cause;
  logic                waiting;
  logic                timeout;
  logic [ALU_OP_W-1:0] dec_op;

  assign waiting = (state == FETCH) || (state == MEM);
  // A ready arriving on the MAX_WAIT cycle still wins over the timeout.
  assign timeout = waiting && !bus.mem_ready && (wait_cnt == CNT_W'(MAX_WAIT));

  alu_op_decoder #(.ALU_OP_W(ALU_OP_W)) u_alu_op_decoder (
    .cls       (cls),
    .funct3    (bus.funct3),
    .funct7_b5 (bus.funct7_b5),
    .alu_op    (dec_op)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      cls      <= CLS_R;
      wait_cnt <= '0;
      cause    <= CAUSE_NONE;
    end else begin
      state <= next_state;
      if (state == DECODE) cls <= classify(bus.opcode);
      // Any state change clears the counter, which covers entry to FETCH/MEM.
      if (next_state != state)             wait_cnt <= '0;
      else if (waiting && !bus.mem_ready)  wait_cnt <= wait_cnt + CNT_W'(1);
      if (next_state == TRAP && state != TRAP)
        cause <= timeout ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (bus.mem_ready)  next_state = DECODE;
        else if (timeout)   next_state = TRAP;
      end
      DECODE: next_state = (classify(bus.opcode) == CLS_ILLEGAL) ? TRAP : EXEC;
      EXEC: begin
        case (cls)
          CLS_R, CLS_I:         next_state = WB;
          CLS_LOAD, CLS_STORE:  next_state = MEM;
          CLS_BRANCH:           next_state = FETCH;
          default:              next_state = TRAP;
        endcase
      end
      MEM: begin
        if (bus.mem_ready)  next_state = (cls == CLS_LOAD) ? WB : FETCH;
        else if (timeout)   next_state = TRAP;
      end
      WB:      next_state = FETCH;
      TRAP:    next_state = TRAP;
      default: next_state = TRAP;
    endcase
  end

  // Outputs are forced low while rst_n is asserted so a request in flight
  // drops asynchronously instead of waiting for the state register.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.alu_src    = 1'b0;
    bus.alu_op     = '0;
    bus.branch     = 1'b0;
    bus.state_o    = 3'd0;
    bus.trap       = 1'b0;
    bus.trap_cause = CAUSE_NONE;
    if (rst_n) begin
      bus.state_o    = state;
      bus.trap_cause = cause;
      case (state)
        FETCH: begin
          bus.mem_read = 1'b1;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
        end
        EXEC: begin
          bus.alu_op  = dec_op;
          bus.alu_src = (cls != CLS_R) && (cls != CLS_BRANCH);
          if (cls == CLS_BRANCH) begin
            bus.branch   = 1'b1;
            bus.pc_write = 1'b1;
          end
        end
        MEM: begin
          bus.mem_read  = (cls == CLS_LOAD);
          bus.mem_write = (cls == CLS_STORE);
        end
        WB:      bus.reg_write = 1'b1;
        TRAP:    bus.trap      = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (MAX_WAIT = 4).
// A reference model expands each instruction into its expected per-cycle
// trace of outputs from the instruction-level rules; the bench then replays
// the trace against the DUT and compares every cycle.
module tb_multicycle_control_unit;

  localparam int MAX_WAIT = 4;
  localparam int ALU_OP_W = 4;

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4, K_ILL = 5;
  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC = 2, ST_MEM = 3, ST_WB = 4, ST_TRAP = 7;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       branch;
    logic [2:0] state;
    logic       trap;
    logic [1:0] cause;
  } vec_t;

  typedef struct {
    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7;
    logic       ready;
    vec_t       exp;
    string      tag;
  } step_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALU_OP_W(ALU_OP_W)) bus ();

  multicycle_control_unit #(.ALU_OP_W(ALU_OP_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    errors = 0;
  int    checks = 0;
  step_t q[$];

  // ALU code per funct3 for the non-alternate (bit 30 clear) operations.
  logic [3:0] base_alu [8] = '{4'b0010, 4'b1000, 4'b0111, 4'b0101,
                               4'b0011, 4'b1001, 4'b0001, 4'b0000};
  logic [6:0] legal_op [5] = '{7'b0110011, 7'b0010011, 7'b0000011,
                               7'b0100011, 7'b1100011};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t observe();
    return {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write,
            bus.alu_src, bus.alu_op, bus.branch, bus.state_o, bus.trap, bus.trap_cause};
  endfunction

  function automatic int kind_of(input logic [6:0] opc);
    for (int i = 0; i < 5; i++) if (legal_op[i] == opc) return i;
    return K_ILL;
  endfunction

  function automatic logic [3:0] ref_alu(input int kind, input logic [2:0] f3, input logic f7);
    if (kind == K_LOAD || kind == K_STORE) return 4'b0010;
    if (kind == K_BRANCH)                  return 4'b0110;
    if (kind == K_R && f3 == 3'd0 && f7)   return 4'b0110;
    if (f3 == 3'd5 && f7)                  return 4'b1010;
    return base_alu[f3];
  endfunction

  function automatic vec_t at_state(input int st);
    vec_t e = '0;
    e.state = 3'(st);
    return e;
  endfunction

  function automatic void push(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                               input logic ready, input vec_t e, input string tag);
    step_t s;
    s.opcode = opc; s.f3 = f3; s.f7 = f7; s.ready = ready; s.exp = e; s.tag = tag;
    q.push_back(s);
  endfunction

  function automatic void add_trap(input logic [1:0] cause, input string name);
    vec_t e = at_state(ST_TRAP);
    e.trap  = 1'b1;
    e.cause = cause;
    for (int i = 0; i < 20; i++)
      push(7'h7F, 3'd0, 1'b0, 1'($urandom), e, $sformatf("%s/trap%0d", name, i));
  endfunction

  // Memory wait: ready arrives on wait cycle `delay` (0-based); no ready in
  // MAX_WAIT+1 cycles means a timeout. Returns 1 when the access timed out.
  function automatic bit add_wait(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                  input int st, input int kind, input int delay, input string name);
    for (int i = 0; i <= MAX_WAIT; i++) begin
      vec_t e = at_state(st);
      logic r = (i == delay);
      if (st == ST_FETCH) begin
        e.mem_read = 1'b1;
        e.ir_write = r;
        e.pc_write = r;
      end else begin
        e.mem_read  = (kind == K_LOAD);
        e.mem_write = (kind == K_STORE);
      end
      push(opc, f3, f7, r, e, $sformatf("%s/%s%0d", name, (st == ST_FETCH) ? "fetch" : "mem", i));
      if (r) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Expands one instruction into expected cycles; returns 1 if it ends in TRAP.
  function automatic bit add_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                   input int fdelay, input int mdelay, input string name);
    int   kind = kind_of(opc);
    vec_t e;
    if (add_wait(opc, f3, f7, ST_FETCH, kind, fdelay, name)) begin
      add_trap(2'b10, name);
      return 1'b1;
    end
    push(opc, f3, f7, 1'($urandom), at_state(ST_DECODE), {name, "/decode"});
    if (kind == K_ILL) begin
      add_trap(2'b01, name);
      return 1'b1;
    end
    e         = at_state(ST_EXEC);
    e.alu_op  = ref_alu(kind, f3, f7);
    e.alu_src = (kind == K_I || kind == K_LOAD || kind == K_STORE);
    e.branch  = (kind == K_BRANCH);
    e.pc_write = (kind == K_BRANCH);
    push(opc, f3, f7, 1'($urandom), e, {name, "/exec"});
    if (kind == K_BRANCH) return 1'b0;
    if (kind == K_LOAD || kind == K_STORE) begin
      if (add_wait(opc, f3, f7, ST_MEM, kind, mdelay, name)) begin
        add_trap(2'b10, name);
        return 1'b1;
      end
      if (kind == K_STORE) return 1'b0;
    end
    e           = at_state(ST_WB);
    e.reg_write = 1'b1;
    push(opc, f3, f7, 1'($urandom), e, {name, "/wb"});
    return 1'b0;
  endfunction

  // Replays n queued cycles (all when n < 0): drive just after posedge,
  // compare at negedge.
  task automatic run(input int n);
    int cnt = 0;
    while (q.size() > 0 && (n < 0 || cnt < n)) begin
      step_t s = q.pop_front();
      bus.opcode    = s.opcode;
      bus.funct3    = s.f3;
      bus.funct7_b5 = s.f7;
      bus.mem_ready = s.ready;
      @(negedge clk);
      check(s.tag, observe(), s.exp);
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.opcode    = '0;
    bus.funct3    = '0;
    bus.funct7_b5 = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("reset/outputs", observe(), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    #1;
    do_reset();

    // Directed sequence: ADD x10,x10,x11 with ready high, delayed load,
    // SUB, branch, then an illegal opcode that must trap.
    void'(add_instr(7'b0110011, 3'd0, 1'b0, 0, 0, "add"));
    void'(add_instr(7'b0000011, 3'd2, 1'b0, 0, 3, "load_d3"));
    void'(add_instr(7'b0110011, 3'd0, 1'b1, 1, 0, "sub"));
    void'(add_instr(7'b0010011, 3'd5, 1'b1, 2, 0, "srai"));
    void'(add_instr(7'b0010011, 3'd0, 1'b1, 0, 0, "addi_b30"));
    void'(add_instr(7'b1100011, 3'd1, 1'b1, 0, 0, "branch"));
    void'(add_instr(7'h7F, 3'd0, 1'b0, 0, 0, "illegal"));
    run(-1);

    // Fetch timeout, then the same access completing on the last allowed cycle.
    do_reset();
    void'(add_instr(7'b0110011, 3'd7, 1'b0, MAX_WAIT + 1, 0, "fetch_to"));
    run(-1);
    do_reset();
    void'(add_instr(7'b0110011, 3'd6, 1'b0, MAX_WAIT, 0, "fetch_edge"));
    void'(add_instr(7'b0100011, 3'd2, 1'b0, 0, MAX_WAIT, "store_edge"));
    void'(add_instr(7'b0000011, 3'd2, 1'b0, 0, MAX_WAIT + 1, "load_to"));
    run(-1);

    // Reset asserted mid-store: the write strobe must drop without a clock.
    do_reset();
    void'(add_instr(7'b0100011, 3'd2, 1'b0, 0, 3, "st_rst"));
    run(5);
    bus.mem_ready = 1'b0;
    #1;
    check("st_rst/pre_write", 32'(bus.mem_write), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("st_rst/async_drop", observe(), '0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    void'(add_instr(7'b0010011, 3'd4, 1'b0, 0, 0, "after_rst"));
    run(-1);

    // Randomized segments of instructions with random memory latencies.
    for (int seg = 0; seg < 40; seg++) begin
      int n = $urandom_range(1, 6);
      do_reset();
      for (int k = 0; k < n; k++) begin
        logic [6:0] opc;
        int fd, md;
        if ($urandom_range(0, 19) == 0) begin
          do opc = 7'($urandom); while (kind_of(opc) != K_ILL);
        end else begin
          opc = legal_op[$urandom_range(0, 4)];
        end
        fd = ($urandom_range(0, 9) == 0) ? MAX_WAIT + 1 : $urandom_range(0, MAX_WAIT);
        md = ($urandom_range(0, 9) == 0) ? MAX_WAIT + 1 : $urandom_range(0, MAX_WAIT);
        if (add_instr(opc, 3'($urandom), 1'($urandom), fd, md,
                      $sformatf("rnd%0d.%0d", seg, k)))
          break;
      end
      run(-1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle control FSM for the RV32I core; successor to the single-cycle combinational opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and issues per-state datapath strobes.
- Handshakes with instruction/data memory through mem_ready and enforces a bounded wait with a timeout trap.
- Sits between the instruction register/register file/ALU datapath and the unified memory port.

Parameters:
- ALU_OP_W, 4, width of alu_op; values 5..8 zero-extend the encodings below.
- MAX_WAIT, 16, maximum cycles spent waiting for mem_ready before a trap; legal range 1..255.
- CNT_W, $clog2(MAX_WAIT+1), width of the wait counter; derived, never overridden.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instr[6:0] from the instruction register, valid from DECODE onward.
- funct3  in  3  instr[14:12].
- funct7_b5  in  1  instr[30].
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC <= PC+4 (FETCH completion) or branch target (EXEC, branch taken in datapath).
- ir_write  out  1  load instruction register.
- reg_write  out  1  register file write enable.
- mem_read  out  1  memory read request, held until mem_ready.
- mem_write  out  1  memory write request, held until mem_ready.
- alu_src  out  1  0 = rs2, 1 = immediate.
- alu_op  out  ALU_OP_W  ALU operation.
- branch  out  1  datapath evaluates the branch condition this cycle.
- state_o  out  3  current state encoding, for debug.
- trap  out  1  sticky; the FSM is in TRAP.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout.

Behaviour:
- Reset (async assert, sync release): state = FETCH, wait counter = 0, trap_cause = 00, and every output is 0 while rst_n is low. The first cycle after release is FETCH with mem_read = 1.
- Output timing: outputs are decoded from the state register plus the latched instruction class (Moore, plus a mem_ready qualifier in waiting states). An instruction takes 3-5 cycles plus memory wait cycles.
- FETCH:
  - Drives mem_read = 1.
  - On mem_ready: ir_write = 1 and pc_write = 1 in the same cycle, then go to DECODE.
- DECODE (1 cycle):
  - Classify the opcode and latch the class: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH.
  - Any other opcode goes to TRAP with cause 01.
- EXEC (1 cycle):
  - R: alu_src = 0; alu_op from funct3/funct7_b5.
  - I-ALU: alu_src = 1; alu_op from funct3. funct7_b5 is used only when funct3 = 101.
  - LOAD/STORE: alu_src = 1, alu_op = ADD.
  - BRANCH: alu_src = 0, alu_op = SUB, branch = 1, pc_write = 1, then go to FETCH.
  - Next state: R/I go to WB; LOAD/STORE go to MEM.
- MEM:
  - LOAD holds mem_read = 1; STORE holds mem_write = 1.
  - On mem_ready: LOAD goes to WB; STORE goes to FETCH.
- WB (1 cycle): reg_write = 1, then go to FETCH.
- ALU encodings (4-bit): ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, SLT 0111, SLTU 0101, SLL 1000, SRL 1001, SRA 1010.
  - funct7_b5 = 1 with funct3 = 000 selects SUB for R-type only.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle mem_ready is low in those states.
  - If the counter reaches MAX_WAIT with mem_ready still low, go to TRAP with cause 10 and drop the request.
  - mem_ready high in the same cycle the count hits MAX_WAIT: the access completes, no trap.
- mem_ready outside FETCH/MEM is ignored.
- TRAP: all strobes are 0, trap = 1, trap_cause holds. Only rst_n exits TRAP.
- Reset mid-access: requests drop immediately (asynchronously); no partial write strobe survives.

Decomposition:
- Shared package `rv_ctrl_pkg` holds:
  - opcode localparams;
  - the state_t enum (FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7);
  - the instr_class_t enum;
  - the alu_op localparams;
  - the trap cause codes.
- One sub-module, `alu_op_decoder`: combinational class/funct3/funct7_b5 -> alu_op; shared with future pipelined cores.

Test Plan:
- Reset with rst_n = 0 mid-MEM of a store -> mem_write drops to 0 asynchronously; after release state_o = 0 and mem_read = 1.
- R-type ADD 0x00B50533, mem_ready tied high:
  - cycle 0 ir_write = 1 and pc_write = 1;
  - cycle 2 alu_op = 0010, alu_src = 0;
  - cycle 3 reg_write = 1;
  - cycle 4 back in FETCH.
- Load, opcode 0000011, with mem_ready delayed 3 cycles in MEM -> mem_read held for exactly 4 cycles, then reg_write = 1 for one cycle; SUB variant: funct7_b5 = 1 in an R-type gives alu_op = 0110.
- Branch, opcode 1100011 -> in EXEC branch = 1, pc_write = 1, alu_op = 0110; next state FETCH, and reg_write is never asserted.
- Illegal opcode 0x7F -> after DECODE, trap = 1, trap_cause = 01, all strobes 0 for 20+ cycles until reset.
- MAX_WAIT = 4 with mem_ready never asserted in FETCH -> trap_cause = 10 on the 5th cycle after FETCH entry. Boundary case: mem_ready asserted on the 4th wait cycle completes normally with no trap.
